// File: rtl/apb_wait_regfile_if.sv
// APB completer-side bus bundle: master drives request, slave drives response.
interface apb_wait_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_wait_regfile.sv
// APB completer with a word register bank, fixed wait states and PSLVERR.
// Map: scratch RW regs at idx 0..NUM_REGS-3, write counter at NUM_REGS-2,
// constant ID at NUM_REGS-1. All response outputs are registered.
module apb_wait_regfile #(
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_wait_regfile_if.slave   apb
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam int unsigned NUM_SCRATCH = NUM_REGS - 2;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] wcount_q, wcount_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_SCRATCH];
  logic [DATA_WIDTH-1:0] regs_d [NUM_SCRATCH];

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [31:0]           req_idx;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] req_rdata;
  logic [31:0]           commit_idx;
  logic                  commit;

  // Response decode. With zero wait states the response is formed on the
  // setup edge, so the live bus is the request source while idle.
  always_comb begin
    req_addr  = (state_q == IDLE) ? apb.PADDR  : addr_q;
    req_write = (state_q == IDLE) ? apb.PWRITE : write_q;
    req_idx   = 32'(req_addr[ADDR_WIDTH-1:2]);
    req_err   = (req_addr[1:0] != 2'b00) ||
                (req_idx >= NUM_REGS) ||
                (req_write && (req_idx >= NUM_SCRATCH));
    req_rdata = '0;
    if (!req_err && !req_write) begin
      if (req_idx == NUM_REGS - 1) begin
        req_rdata = ID_VALUE;
      end else if (req_idx == NUM_SCRATCH) begin
        req_rdata = wcount_q;
      end else begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (req_idx == i) begin
            req_rdata = regs_q[i];
          end
        end
      end
    end
  end

  // Transfer FSM: latch at setup, count wait states, present and complete.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (apb.PSEL && !apb.PENABLE) begin
          addr_d  = apb.PADDR;
          write_d = apb.PWRITE;
          wdata_d = apb.PWDATA;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = req_err;
            prdata_d  = req_rdata;
          end
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (pready_q) begin
          if (apb.PENABLE) begin
            commit    = write_q && !pslverr_q;
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end
        end else begin
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = req_err;
            prdata_d  = req_rdata;
          end
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register bank and write counter update on a legal write completion.
  always_comb begin
    commit_idx = 32'(addr_q[ADDR_WIDTH-1:2]);
    regs_d     = regs_q;
    wcount_d   = wcount_q;
    if (commit) begin
      wcount_d = wcount_q + 1'b1;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        if (commit_idx == i) begin
          regs_d[i] = wdata_q;
        end
      end
    end
  end

  // State flops with asynchronous active-low reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wcount_q  <= '0;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wcount_q  <= wcount_d;
      regs_q    <= regs_d;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;

endmodule
